// File: rtl/gpu_cap_reader.sv
// gpu_cap_reader: reads a burst of words from a combinational capability table
// into a 4-entry FIFO and streams them out with valid/ready handshaking.
// Optional feature macro: GPU_CAP_RANGE_CHECK_EN. When it is defined, indices
// >= 2 return zero data flagged with oRspError.
`ifndef GPU_WORD
`define GPU_WORD [31:0]
`endif

module gpu_cap_reader (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iReqValid,
  output logic            oReqReady,
  input  logic [4:0]      iReqAddr,
  input  logic [4:0]      iReqLen,
  output logic [4:0]      oGpuCapabilitesAddr,
  input  logic `GPU_WORD  iGpuCapabilitesData,
  output logic            oRspValid,
  input  logic            iRspReady,
  output logic `GPU_WORD  oRspData,
  output logic            oRspLast,
  output logic            oRspError,
  output logic            oBusy
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [4:0]     addr_q, addr_d;
  logic [4:0]     rem_q, rem_d;
  logic [2:0]     count_q, count_d;
  logic [1:0]     wptr_q, wptr_d;
  logic [1:0]     rptr_q, rptr_d;
  logic           rdy_q, rdy_d;
  logic `GPU_WORD fifo_data_q [4];
  logic [3:0]     fifo_last_q;
  logic `GPU_WORD push_data;
  logic           push, pop, accept;

`ifdef GPU_CAP_RANGE_CHECK_EN
  logic           push_err;
  logic [3:0]     fifo_err_q;

  // Only indices 0 and 1 exist; anything beyond returns zero with an error flag.
  always_comb begin
    push_err  = (addr_q >= 5'd2);
    push_data = push_err ? '0 : iGpuCapabilitesData;
  end

  assign oRspError = oRspValid & fifo_err_q[rptr_q];
`else
  assign push_data = iGpuCapabilitesData;
  assign oRspError = 1'b0;
`endif

  // Request handshake is held off until the first clock after reset release.
  assign oReqReady           = rdy_q && (state_q == IDLE);
  assign oRspValid           = (count_q != 3'd0);
  assign oRspData            = oRspValid ? fifo_data_q[rptr_q] : '0;
  assign oRspLast            = oRspValid & fifo_last_q[rptr_q];
  assign oBusy               = (state_q != IDLE) || (count_q != 3'd0);
  assign oGpuCapabilitesAddr = addr_q;

  // FIFO bookkeeping and the IDLE -> FETCH -> DRAIN sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdy_d   = 1'b1;
    accept  = iReqValid && oReqReady;
    pop     = oRspValid && iRspReady;
    push    = (state_q == FETCH) && ((count_q != 3'd4) || pop);

    if (push) wptr_d = wptr_q + 2'd1;
    if (pop)  rptr_d = rptr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = iReqAddr;
          rem_d   = iReqLen;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (push) begin
          addr_d = addr_q + 5'd1;
          rem_d  = rem_q - 5'd1;
          if (rem_q == 5'd0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset discards any in-flight burst by emptying the FIFO.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdy_q   <= rdy_d;
    end
  end

  // FIFO storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data_q[wptr_q] <= push_data;
      fifo_last_q[wptr_q] <= (rem_q == 5'd0);
`ifdef GPU_CAP_RANGE_CHECK_EN
      fifo_err_q[wptr_q]  <= push_err;
`endif
    end
  end

endmodule

// File: tb/tb_gpu_cap_reader.sv
// Testbench for gpu_cap_reader: directed requests, a queue-based burst model
// checked every cycle, and literal expectations for the key scenarios.
`ifndef GPU_WORD
`define GPU_WORD [31:0]
`endif
`ifndef GPU_AABB_COUNT
`define GPU_AABB_COUNT 1024
`endif
`ifndef SCALE
`define SCALE 256
`endif

module tb_gpu_cap_reader;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic [4:0]  iReqAddr = '0;
  logic [4:0]  iReqLen = '0;
  logic [4:0]  oGpuCapabilitesAddr;
  logic [31:0] iGpuCapabilitesData;
  logic        oRspValid;
  logic        iRspReady = 1'b1;
  logic [31:0] oRspData;
  logic        oRspLast;
  logic        oRspError;
  logic        oBusy;

  gpu_cap_reader dut (
    .Clock(Clock), .Reset(Reset), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqAddr(iReqAddr), .iReqLen(iReqLen), .oGpuCapabilitesAddr(oGpuCapabilitesAddr),
    .iGpuCapabilitesData(iGpuCapabilitesData), .oRspValid(oRspValid),
    .iRspReady(iRspReady), .oRspData(oRspData), .oRspLast(oRspLast),
    .oRspError(oRspError), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  // Capability table: index 0/1 are the documented entries, others unique.
  function automatic logic [31:0] tbl(input logic [4:0] i);
    if (i == 5'd0) return 32'd`GPU_AABB_COUNT;
    if (i == 5'd1) return 32'd`SCALE;
    return {27'd0, i ^ 5'h15};
  endfunction

  assign iGpuCapabilitesData = tbl(oGpuCapabilitesAddr);

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        err;
  } word_t;

  function automatic word_t model_word(input logic [4:0] idx, input logic last);
    word_t w;
    w.last = last;
`ifdef GPU_CAP_RANGE_CHECK_EN
    w.err = (idx >= 5'd2);
    w.d   = w.err ? 32'h0 : tbl(idx);
`else
    w.err = 1'b0;
    w.d   = tbl(idx);
`endif
    return w;
  endfunction

  word_t       exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the burst model.
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("reset_outputs",
          {oReqReady, oRspValid, oRspData, oRspLast, oRspError, oBusy, oGpuCapabilitesAddr},
          '0);
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {oRspValid, oRspData}, {1'b1, hold_d});
      if (oRspValid) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rsp_data", oRspData, exp_q[0].d);
          chk("rsp_last", oRspLast, exp_q[0].last);
          chk("rsp_error", oRspError, exp_q[0].err);
          if (iRspReady) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      hold_v = oRspValid && !iRspReady;
      hold_d = oRspData;
      if (iReqValid && oReqReady) begin
        for (int i = 0; i <= int'(iReqLen); i++)
          exp_q.push_back(model_word(iReqAddr + 5'(i), i == int'(iReqLen)));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic request(input logic [4:0] a, input logic [4:0] l);
    iReqAddr  = a;
    iReqLen   = l;
    iReqValid = 1'b1;
    chk("req_ready", oReqReady, 1);
    tick();
    iReqValid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!oBusy) break;
      tick();
    end
    chk("idle_timeout", oBusy, 0);
  endtask

  initial begin
    int p0;
    #1;
    chk("rst_ready", oReqReady, 0);
    chk("rst_valid", oRspValid, 0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    chk("ready_after_release", oReqReady, 1);
    chk("busy_after_release", oBusy, 0);

    // Single read of index 0
    request(5'd0, 5'd0);
    chk("t1_no_valid_n1", oRspValid, 0);
    tick();
    chk("t1_valid_n2", oRspValid, 1);
    chk("t1_data", oRspData, 32'd1024);
    chk("t1_last", oRspLast, 1);
    tick();
    chk("t1_ready_back", oReqReady, 1);
    chk("t1_idle", oBusy, 0);

    // Two-word burst
    request(5'd0, 5'd1);
    chk("t2_no_valid_n1", oRspValid, 0);
    tick();
    chk("t2_w0", {oRspValid, oRspData, oRspLast}, {1'b1, 32'd1024, 1'b0});
    tick();
    chk("t2_w1", {oRspValid, oRspData, oRspLast}, {1'b1, 32'd256, 1'b1});
    chk("t2_not_ready", oReqReady, 0);
    tick();
    chk("t2_ready_back", oReqReady, 1);
    chk("t2_empty", oRspValid, 0);

    // Backpressure: 8-word burst, consumer stalled 10 cycles
    iRspReady = 1'b0;
    request(5'd0, 5'd7);
    repeat (10) tick();
    chk("t3_valid", oRspValid, 1);
    chk("t3_head", oRspData, 32'd1024);
    chk("t3_addr_frozen", oGpuCapabilitesAddr, 5'd4);
    chk("t3_busy", oBusy, 1);
    p0 = n_pop;
    iRspReady = 1'b1;
    wait_idle(40);
    chk("t3_word_count", n_pop - p0, 8);
    chk("t3_model_empty", exp_q.size(), 0);

    // Address wrap 31 -> 0 -> 1
    request(5'd31, 5'd2);
    tick();
`ifdef GPU_CAP_RANGE_CHECK_EN
    chk("t4_first", {oRspValid, oRspData, oRspError}, {1'b1, 32'h0, 1'b1});
`else
    chk("t4_first", {oRspValid, oRspData, oRspError}, {1'b1, 32'h0000000A, 1'b0});
`endif
    wait_idle(20);
    chk("t4_model_empty", exp_q.size(), 0);

    // Irregular consumer on a 10-word burst
    p0 = n_pop;
    request(5'd5, 5'd9);
    for (int i = 0; i < 80; i++) begin
      if (!oBusy) break;
      iRspReady = ($urandom_range(0, 2) != 0);
      tick();
    end
    iRspReady = 1'b1;
    wait_idle(20);
    chk("t5_word_count", n_pop - p0, 10);
    chk("t5_model_empty", exp_q.size(), 0);

    // Reset during the third word of a 16-word burst
    request(5'd0, 5'd15);
    tick(); tick(); tick();
    chk("t6_mid_burst", oRspValid, 1);
    Reset = 1'b0;
    #1;
    chk("t6_rst_outs",
        {oReqReady, oRspValid, oRspData, oRspLast, oRspError, oBusy, oGpuCapabilitesAddr}, '0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    chk("t6_ready", oReqReady, 1);
    for (int i = 0; i < 12; i++) begin
      chk("t6_no_residual", {oRspValid, oBusy}, 2'b00);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpu_cap_reader.md
GPU_CAP_READER -- requirements
Module: gpu_cap_reader

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock (rising edge); Reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have iReqValid  in  1  read request strobe, and oReqReady  out  1  request accepted when high with iReqValid.
REQ-003 SHALL have iReqAddr  in  5  first capability index, and iReqLen  in  5  word count minus one (0 = 1 word, 31 = 32 words).
REQ-004 SHALL have oGpuCapabilitesAddr  out  5  index driven to the capability table.
REQ-005 SHALL have iGpuCapabilitesData  in  `GPU_WORD  combinational table data for oGpuCapabilitesAddr.
REQ-006 SHALL have oRspValid  out  1  response word available, and iRspReady  in  1  consumer accepts word.
REQ-007 SHALL have oRspData  out  `GPU_WORD  response word; oRspLast  out  1  final word of burst; oRspError  out  1  out-of-range index (see REQ-022).
REQ-008 SHALL have oBusy  out  1  high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-010 SHALL assert oReqReady only in IDLE; a request is accepted on a cycle with iReqValid=1 and oReqReady=1.
REQ-011 On acceptance SHALL load address register <= iReqAddr, remaining counter <= iReqLen, and go to FETCH.
REQ-012 In FETCH SHALL drive oGpuCapabilitesAddr from the address register and push {iGpuCapabilitesData, last, error} into a 4-entry FIFO on each cycle a push is allowed.
REQ-013 A push SHALL be allowed when FIFO count < 4, or count == 4 with a pop in the same cycle.
REQ-014 After each push SHALL increment the address modulo 32 (31 wraps to 0) and decrement the remaining counter.
REQ-015 The push whose remaining counter equals 0 SHALL carry last=1 and move the FSM to DRAIN.
REQ-016 DRAIN SHALL return to IDLE on the cycle the FIFO becomes empty; a new request is accepted no earlier than the following cycle.
REQ-017 oRspValid SHALL equal FIFO non-empty; oRspData/oRspLast/oRspError SHALL present the head entry and hold stable while oRspValid=1 and iRspReady=0.
REQ-018 A pop SHALL occur when oRspValid=1 and iRspReady=1; simultaneous push and pop SHALL leave count unchanged.
REQ-019 Latency: request accepted in cycle N, first push at end of N+1, oRspValid=1 in N+2; with iRspReady held high, one word per cycle thereafter.
REQ-020 oGpuCapabilitesAddr SHALL hold its last value in IDLE and DRAIN.

Reset
REQ-021 Reset low SHALL asynchronously force: FSM=IDLE, FIFO count=0, address register=0, remaining counter=0, oReqReady=0 while Reset low then 1 after release, oRspValid=0, oRspData=0, oRspLast=0, oRspError=0, oBusy=0, oGpuCapabilitesAddr=0; an in-flight burst is discarded with no further words emitted.

Configuration
REQ-022 With GPU_CAP_RANGE_CHECK_EN defined, an index >= 2 SHALL push data 32'h0 with error=1; indices 0 and 1 push table data with error=0.
REQ-023 Without GPU_CAP_RANGE_CHECK_EN, every index SHALL push raw table data, oRspError SHALL be tied 0, and no comparator logic SHALL be present.

Verification
REQ-024 Single read: iReqAddr=0, iReqLen=0, iRspReady=1 -> one word = 32'd`GPU_AABB_COUNT, oRspLast=1, oRspValid first high two cycles after acceptance.
REQ-025 Burst: iReqAddr=0, iReqLen=1 -> words `GPU_AABB_COUNT then `SCALE on consecutive cycles, oRspLast only on the second, oReqReady returns high one cycle after the FIFO empties.
REQ-026 Backpressure: iReqAddr=0, iReqLen=7, iRspReady=0 for 10 cycles -> exactly 4 entries buffered, oRspData stable, address frozen; release -> 8 words in order, none lost or duplicated.
REQ-027 Wrap and range: iReqAddr=31, iReqLen=2 -> indices 31,0,1; with GPU_CAP_RANGE_CHECK_EN first word 32'h0 with oRspError=1; without it first word 32'h0000000A, oRspError=0.
REQ-028 Reset mid-burst: Reset low during word 3 of a 16-word burst -> all outputs at reset values within the same cycle; after release oReqReady=1 and no residual words appear.
